nios_system_pio_in: RTL and testbench

NIOS_SYSTEM_PIO_IN -- requirements
Module: nios_system_pio_in

---
 rtl/nios_system_pio_in.sv | 154 +++++++++++++++
 tb/tb_nios_system_pio_in.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_pio_in.sv
// nios_system_pio_in
// Avalon-MM parallel input port with per-bit edge capture and a level
// interrupt. Register map (word address):
//   0  data        (RO)   sampled input value
//   1  reserved    (RO)   reads 0, writes ignored
//   2  irqmask     (RW)   per-bit interrupt enable
//   3  edgecapture (RW1C) sticky edge flags; writing 1 clears a bit
//
// Parameters:
//   WIDTH      input width in bits, 1..32
//   EDGE_TYPE  0 = rising, 1 = falling, 2 = any edge
//
// Build option:
//   NIOS_SYSTEM_PIO_IN_SYNC_EN  when defined, in_port passes through a
//   two-flop synchronizer before the data register (2 extra cycles of
//   latency). When undefined, in_port feeds the data register directly.

module nios_system_pio_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_edge_evt;
    logic [WIDTH-1:0] w_edge_clr;
    logic [WIDTH-1:0] w_edgecap_nxt;
    logic [31:0]      w_rd_mux;

    // Upper writedata bits beyond WIDTH carry no state; fold them so the
    // full bus is visibly consumed.
    logic             w_unused_wdata;
    assign w_unused_wdata = ^writedata;

`ifdef NIOS_SYSTEM_PIO_IN_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two-flop synchronizer for asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = in_port;
`endif

    assign w_wr_en = chipselect & ~write_n;
    assign w_rd_en = chipselect & ~read_n;

    // Data and previous-value pipeline used for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_prev <= '0;
        end else begin
            r_data <= w_sample;
            r_prev <= r_data;
        end
    end

    // Per-bit edge event selected by EDGE_TYPE.
    always_comb begin
        w_edge_evt = '0;
        case (EDGE_TYPE)
            0:       w_edge_evt = r_data & ~r_prev;
            1:       w_edge_evt = ~r_data & r_prev;
            default: w_edge_evt = r_data ^ r_prev;
        endcase
    end

    // Write-one-to-clear mask; new events are OR-ed in afterwards so a
    // coincident set beats the clear.
    always_comb begin
        w_edge_clr = '0;
        if (w_wr_en && (address == ADDR_EDGE)) begin
            w_edge_clr = writedata[WIDTH-1:0];
        end
        w_edgecap_nxt = (r_edgecap & ~w_edge_clr) | w_edge_evt;
    end

    // Sticky edge-capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= w_edgecap_nxt;
        end
    end

    // Interrupt mask register; writes to other addresses are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
        end else if (w_wr_en && (address == ADDR_MASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux over current (pre-write) register values, zero-extended.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux[WIDTH-1:0] = r_data;
            ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
            ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default:   w_rd_mux = '0;
        endcase
    end

    // Registered read data: one-cycle latency, zero when no read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_rd_en) begin
            r_readdata <= w_rd_mux;
        end else begin
            r_readdata <= '0;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_system_pio_in.sv
// Directed testbench for nios_system_pio_in (WIDTH=8, EDGE_TYPE=0).
// Input-to-data latency follows NIOS_SYSTEM_PIO_IN_SYNC_EN: 3 clocks with
// the synchronizer, 1 clock without; edge capture lands one clock later.

module tb_nios_system_pio_in;

`ifdef NIOS_SYSTEM_PIO_IN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    nios_system_pio_in #(.WIDTH(8), .EDGE_TYPE(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        tick(1);
        chipselect = 1'b0;
        read_n     = 1'b1;
        d          = readdata;
    endtask

    initial begin
        logic [31:0] v;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        in_port    = 8'h00;

        tick(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(3);

        // Data path and read latency
        in_port = 8'hA5;
        tick(4);
        rd(2'd0, v);
        check("data_a5", v, 32'h000000A5);
        tick(1);
        check("rd_idle_zero", readdata, 32'h0);

        // Rising edges of A5 captured; no irq with mask 0
        rd(2'd3, v);
        check("ec_a5", v, 32'h000000A5);
        check("irq_masked_a5", {31'h0, irq}, 32'h0);
        rd(2'd3, v);
        check("ec_read_no_clear", v, 32'h000000A5);
        wr(2'd3, 32'hFF);
        rd(2'd3, v);
        check("ec_cleared", v, 32'h0);

        // Reserved and data addresses ignore writes
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, v);
        check("reserved_zero", v, 32'h0);
        wr(2'd0, 32'h0);
        rd(2'd0, v);
        check("data_ro", v, 32'h000000A5);

        // irqmask write/read, bit0 rising edge timing
        wr(2'd2, 32'h01);
        rd(2'd2, v);
        check("mask_01", v, 32'h00000001);
        in_port = 8'hA4;
        tick(LAT + 2);
        rd(2'd3, v);
        check("falling_ignored", v, 32'h0);
        in_port = 8'hA5;
        tick(LAT);
        check("irq_before_capture", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_bit0", {31'h0, irq}, 32'h1);
        rd(2'd3, v);
        check("ec_bit0", v, 32'h00000001);
        wr(2'd3, 32'h01);
        check("irq_after_clear", {31'h0, irq}, 32'h0);
        rd(2'd3, v);
        check("ec_after_clear", v, 32'h0);

        // Masked capture, then enable mask
        wr(2'd2, 32'h00);
        in_port = 8'hAD;
        tick(LAT + 2);
        check("irq_masked_bit3", {31'h0, irq}, 32'h0);
        rd(2'd3, v);
        check("ec_bit3", v, 32'h00000008);
        wr(2'd2, 32'h08);
        check("irq_after_mask", {31'h0, irq}, 32'h1);

        // Set wins over coincident clear
        in_port = 8'hA9;
        tick(LAT + 2);
        wr(2'd3, 32'hFF);
        rd(2'd3, v);
        check("ec_clear_all", v, 32'h0);
        in_port = 8'hAD;
        tick(LAT);
        wr(2'd3, 32'h04);
        rd(2'd3, v);
        check("set_wins", v, 32'h00000004);
        wr(2'd3, 32'h04);
        rd(2'd3, v);
        check("clear_bit2", v, 32'h0);

        // Simultaneous read and write returns pre-write value
        chipselect = 1'b1;
        read_n     = 1'b0;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = 32'h55;
        tick(1);
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = 32'h0;
        check("rw_old", readdata, 32'h00000008);
        rd(2'd2, v);
        check("rw_new", v, 32'h00000055);

        // Reset mid-operation with everything set
        in_port = 8'h00;
        tick(LAT + 2);
        wr(2'd3, 32'hFF);
        in_port = 8'hFF;
        tick(LAT + 2);
        wr(2'd2, 32'hFF);
        check("irq_all_set", {31'h0, irq}, 32'h1);
        rd(2'd3, v);
        check("ec_ff", v, 32'h000000FF);
        reset_n = 1'b0;
        #1;
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        check("rst_mid_readdata", readdata, 32'h0);
        in_port = 8'h00;
        tick(3);
        reset_n = 1'b1;
        tick(LAT + 2);
        rd(2'd0, v);
        check("post_rst_data", v, 32'h0);
        rd(2'd2, v);
        check("post_rst_mask", v, 32'h0);
        rd(2'd3, v);
        check("post_rst_ec", v, 32'h0);
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
